// File: rtl/encrypt_pkg.sv
// Shared encodings for the encrypt controller and the encrypt stage:
// FSM states, start/stop handshake codes and result-buffer geometry.
package encrypt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RUN   = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [2:0] ACK      = 3'b001;
  localparam logic [2:0] DONE     = 3'b010;
  localparam logic [1:0] START    = 2'b01;
  localparam logic [1:0] IDLE_CMD = 2'b00;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 9;
  localparam int BUF_DEPTH = 4;
  localparam int BUF_IDX_W = 2;

  // Timeout counter is at least 10 bits wide, wider if TIMEOUT needs it.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 10) ? 10 : w;
  endfunction

endpackage

// File: rtl/encrypt_ctrl_result_buf.sv
// Four-entry result buffer: filled in order during READ, drained in order
// during DRAIN, each side with its own index.
module result_buf
  import encrypt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_adv,
  output logic [DATA_W-1:0]    rd_data,
  output logic [BUF_IDX_W-1:0] rd_idx
);

  logic [BUF_IDX_W-1:0] wr_idx_reg;
  logic [BUF_IDX_W-1:0] rd_idx_reg;
  logic [DATA_W-1:0]    entry [BUF_DEPTH];

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_idx_reg == BUF_IDX_W'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entry[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
    end else if (clr) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_idx_reg <= wr_idx_reg + 1'b1;
      end
      if (rd_adv) begin
        rd_idx_reg <= rd_idx_reg + 1'b1;
      end
    end
  end

  assign rd_data = entry[rd_idx_reg];
  assign rd_idx  = rd_idx_reg;

endmodule

// File: rtl/encrypt_ctrl.sv
// Encrypt job controller: start/stop handshake with the encrypt stage,
// phase timeouts, 4-word result readback and a ready/valid result stream.
module encrypt_ctrl
  import encrypt_pkg::*;
#(
  parameter int                TIMEOUT  = 1023,
  parameter logic [ADDR_W-1:0] RES_BASE = 9'd256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              busy,
  output logic              err,
  output logic [1:0]        start,
  input  logic [2:0]        stop,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int              TO_W      = cnt_width(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [2:0]      READ_LAST = 3'd4;

  state_t               state_reg;
  state_t               state_next;
  logic [TO_W-1:0]      to_cnt_reg;
  logic [2:0]           rd_cnt_reg;
  logic                 timeout_hit;
  logic                 buf_clr;
  logic                 buf_wr_en;
  logic                 buf_adv;
  logic [DATA_W-1:0]    buf_data;
  logic [BUF_IDX_W-1:0] buf_rd_idx;

  // The increment that would make the counter reach TIMEOUT is the exit edge.
  assign timeout_hit = (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (stop == ACK) begin
          state_next = RUN;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      RUN: begin
        if (stop == DONE) begin
          state_next = READ;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      READ: begin
        if (rd_cnt_reg == READ_LAST) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready && (buf_rd_idx == BUF_IDX_W'(BUF_DEPTH - 1))) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        if (go) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_reg <= '0;
      rd_cnt_reg <= '0;
    end else begin
      if (state_next != state_reg) begin
        to_cnt_reg <= '0;
      end else if ((state_reg == REQ) || (state_reg == RUN)) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end

      if (state_reg == READ) begin
        rd_cnt_reg <= rd_cnt_reg + 3'd1;
      end else begin
        rd_cnt_reg <= '0;
      end
    end
  end

  always_comb begin
    start     = IDLE_CMD;
    busy      = 1'b0;
    err       = 1'b0;
    mem_sel   = 1'b0;
    rd_addr   = RES_BASE;
    out_valid = 1'b0;
    out_data  = '0;
    buf_clr   = 1'b0;
    buf_wr_en = 1'b0;
    buf_adv   = 1'b0;
    case (state_reg)
      REQ: begin
        busy  = 1'b1;
        start = START;
      end
      RUN: begin
        busy    = 1'b1;
        buf_clr = (stop == DONE);
      end
      READ: begin
        busy    = 1'b1;
        mem_sel = 1'b1;
        // Cycles 0..3 issue addresses; cycles 1..4 capture the word issued
        // on the previous cycle.
        if (rd_cnt_reg < READ_LAST) begin
          rd_addr = RES_BASE + ADDR_W'(rd_cnt_reg[1:0]);
        end
        buf_wr_en = (rd_cnt_reg != 3'd0);
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = buf_data;
        buf_adv   = out_ready;
      end
      ERR: begin
        err = 1'b1;
      end
      default: begin
      end
    endcase
  end

  result_buf u_result_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (buf_wr_en),
    .wr_data (rd_data),
    .rd_adv  (buf_adv),
    .rd_data (buf_data),
    .rd_idx  (buf_rd_idx)
  );

endmodule

// File: tb/tb_encrypt_ctrl.sv
// Bench for encrypt_ctrl: table of jobs plus hand-written timeout and
// reset-in-DRAIN sequences; result words are checked through a queue.
module tb_encrypt_ctrl;

  typedef struct packed {
    logic [31:0] base;
    logic [7:0]  ack_dly;
    logic [7:0]  done_dly;
    logic        stale;
    logic        go_busy;
    logic [6:0]  ready_pat;
    logic [3:0]  exp_drain;
  } job_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [2:0]  stop = 3'b000;
  logic        out_ready = 1'b0;
  logic [31:0] rd_data = 32'd0;

  logic        busy, err, mem_sel, out_valid;
  logic [1:0]  start;
  logic [8:0]  rd_addr;
  logic [31:0] out_data;

  logic        t_busy, t_err, t_mem_sel, t_out_valid;
  logic [1:0]  t_start;
  logic [8:0]  t_rd_addr;
  logic [31:0] t_out_data;

  logic [31:0] mem [0:511];
  logic [31:0] exp_q [$];
  logic [31:0] exp_word;
  logic [31:0] data_prev = 32'd0;
  logic        stall_prev = 1'b0;
  job_t        jobs [4];
  job_t        fresh;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  encrypt_ctrl u_dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .err(err), .start(start),
    .stop(stop), .mem_sel(mem_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  encrypt_ctrl #(.TIMEOUT(16)) u_dut_to (
    .clk(clk), .reset(reset), .go(go), .busy(t_busy), .err(t_err), .start(t_start),
    .stop(stop), .mem_sel(t_mem_sel), .rd_addr(t_rd_addr), .rd_data(rd_data),
    .out_data(t_out_data), .out_valid(t_out_valid), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: pops the scoreboard on each accepted word and checks
  // that a stalled word stays put.
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("hold_data", out_data, data_prev);
      if (!mem_sel) check("rd_addr_idle", 32'(rd_addr), 32'd256);
      if (out_valid && out_ready) begin
        check("q_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check("out_word", out_data, exp_word);
        end
        $display("xfer out_data=%h", out_data);
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
    check({tag, "_start"},     32'(start),     32'd0);
    check({tag, "_mem_sel"},   32'(mem_sel),   32'd0);
    check({tag, "_rd_addr"},   32'(rd_addr),   32'd256);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  out_data,       32'd0);
  endtask

  task automatic do_reset();
    go = 1'b0;
    stop = 3'b000;
    out_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset");
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!out_valid && waited < 40) begin
      tick();
      waited++;
    end
    check("drain_reached", 32'(out_valid), 32'd1);
  endtask

  task automatic run_job(input job_t j, input int idx);
    int w;
    int d;
    logic [6:0] pat;
    pat = j.ready_pat;
    for (int i = 0; i < 4; i++) begin
      mem[256 + i] = j.base + 32'(i);
      exp_q.push_back(j.base + 32'(i));
    end
    stop = j.stale ? 3'b010 : 3'b000;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("req_busy", 32'(busy), 32'd1);
    for (int c = 0; c < int'(j.ack_dly); c++) begin
      check("req_start", 32'(start), 32'd1);
      tick();
    end
    check("req_still", 32'(start), 32'd1);
    stop = 3'b001;
    tick();
    stop = 3'b000;
    check("run_start", 32'(start), 32'd0);
    for (int c = 0; c < int'(j.done_dly); c++) begin
      if (j.go_busy && c == 2) go = 1'b1;
      tick();
      go = 1'b0;
      check("run_hold", 32'({busy, start}), 32'h4);
    end
    stop = 3'b010;
    tick();
    stop = 3'b000;
    check("read_mem_sel", 32'(mem_sel), 32'd1);
    check("read_addr0", 32'(rd_addr), 32'd256);
    wait_valid(w);
    check("read_len", 32'(w), 32'd5);
    d = 0;
    while (out_valid && d < 20) begin
      out_ready = (d < 7) ? pat[3'(d)] : 1'b1;
      if (j.go_busy && d == 1) go = 1'b1;
      tick();
      go = 1'b0;
      d++;
    end
    out_ready = 1'b0;
    check("drain_cycles", 32'(d), 32'(j.exp_drain));
    check("end_valid", 32'(out_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("job %0d done drain_cycles=%0d", idx, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    jobs[0] = '{base:32'hA0, ack_dly:8'd3, done_dly:8'd20, stale:1'b0, go_busy:1'b0,
                ready_pat:7'b1111111, exp_drain:4'd4};
    jobs[1] = '{base:32'hB0, ack_dly:8'd6, done_dly:8'd4, stale:1'b1, go_busy:1'b0,
                ready_pat:7'b1111111, exp_drain:4'd4};
    jobs[2] = '{base:32'hC0, ack_dly:8'd2, done_dly:8'd5, stale:1'b0, go_busy:1'b0,
                ready_pat:7'b1110100, exp_drain:4'd7};
    jobs[3] = '{base:32'hD0, ack_dly:8'd1, done_dly:8'd6, stale:1'b0, go_busy:1'b1,
                ready_pat:7'b1111111, exp_drain:4'd4};
    fresh   = '{base:32'hF0, ack_dly:8'd2, done_dly:8'd3, stale:1'b0, go_busy:1'b0,
                ready_pat:7'b1111111, exp_drain:4'd4};
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;

    #1;
    do_reset();
    for (int i = 0; i < 4; i++) run_job(jobs[i], i);

    // Timeout on the TIMEOUT=16 instance with stop held at 000.
    do_reset();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("to_req_start", 32'(t_start), 32'd1);
    check("to_req_busy", 32'(t_busy), 32'd1);
    for (int c = 1; c < 16; c++) begin
      tick();
      check("to_no_err_yet", 32'(t_err), 32'd0);
    end
    tick();
    check("to_err", 32'(t_err), 32'd1);
    check("to_err_start", 32'(t_start), 32'd0);
    check("to_err_busy", 32'(t_busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("to_err_hold", 32'(t_err), 32'd1);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    check("to_retry_err", 32'(t_err), 32'd0);
    check("to_retry_start", 32'(t_start), 32'd1);
    check("to_retry_busy", 32'(t_busy), 32'd1);
    $display("timeout sequence done");

    // Reset pulsed in DRAIN after two words are accepted, then a fresh job.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem[256 + i] = 32'hE0 + 32'(i);
      exp_q.push_back(32'hE0 + 32'(i));
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    stop = 3'b001;
    tick();
    stop = 3'b000;
    tick();
    stop = 3'b010;
    tick();
    stop = 3'b000;
    wait_valid(w);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("mid_drain_word", out_data, 32'hE2);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    run_job(fresh, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
